// File: rtl/hack_kbd_pkg.sv
// Shared constants for the PS/2 -> Hack keyboard path: Hack special key codes,
// PS/2 set-2 prefix/shift scan codes and the receiver state type.
package hack_kbd_pkg;

  localparam logic [7:0] HK_ENTER = 8'd128;
  localparam logic [7:0] HK_BKSP  = 8'd129;
  localparam logic [7:0] HK_LEFT  = 8'd130;
  localparam logic [7:0] HK_UP    = 8'd131;
  localparam logic [7:0] HK_RIGHT = 8'd132;
  localparam logic [7:0] HK_DOWN  = 8'd133;
  localparam logic [7:0] HK_HOME  = 8'd134;
  localparam logic [7:0] HK_END   = 8'd135;
  localparam logic [7:0] HK_PGUP  = 8'd136;
  localparam logic [7:0] HK_PGDN  = 8'd137;
  localparam logic [7:0] HK_INS   = 8'd138;
  localparam logic [7:0] HK_DEL   = 8'd139;
  localparam logic [7:0] HK_ESC   = 8'd140;
  localparam logic [7:0] HK_F1    = 8'd141;
  localparam logic [7:0] HK_F2    = 8'd142;
  localparam logic [7:0] HK_F3    = 8'd143;
  localparam logic [7:0] HK_F4    = 8'd144;
  localparam logic [7:0] HK_F5    = 8'd145;
  localparam logic [7:0] HK_F6    = 8'd146;
  localparam logic [7:0] HK_F7    = 8'd147;
  localparam logic [7:0] HK_F8    = 8'd148;
  localparam logic [7:0] HK_F9    = 8'd149;
  localparam logic [7:0] HK_F10   = 8'd150;
  localparam logic [7:0] HK_F11   = 8'd151;
  localparam logic [7:0] HK_F12   = 8'd152;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_hack_keyboard_if.sv
// Pin and result bundle of the PS/2 keyboard block; the host/board side is the
// master (drives the PS/2 lines), the receiver is the slave.
interface ps2_hack_keyboard_if;
  logic        ps_clk;
  logic        ps_data;
  logic [15:0] key_code;
  logic        key_valid;
  logic [7:0]  scan_code;
  logic        frame_err;

  modport master (
    output ps_clk, ps_data,
    input  key_code, key_valid, scan_code, frame_err
  );

  modport slave (
    input  ps_clk, ps_data,
    output key_code, key_valid, scan_code, frame_err
  );
endinterface

// File: rtl/ps2_scan_to_hack.sv
// Combinational PS/2 set-2 scan code to Hack key code table; 0 means unmapped.
module ps2_scan_to_hack
  import hack_kbd_pkg::*;
(
  input  logic       e0,
  input  logic [7:0] scan,
  input  logic       shift,
  output logic [7:0] code
);

  always_comb begin
    code = 8'd0;
    if (e0) begin
      // Extended codes reuse keypad scan codes, so navigation only exists here.
      case (scan)
        8'h6B:   code = HK_LEFT;
        8'h75:   code = HK_UP;
        8'h74:   code = HK_RIGHT;
        8'h72:   code = HK_DOWN;
        8'h6C:   code = HK_HOME;
        8'h69:   code = HK_END;
        8'h7D:   code = HK_PGUP;
        8'h7A:   code = HK_PGDN;
        8'h70:   code = HK_INS;
        8'h71:   code = HK_DEL;
        8'h5A:   code = HK_ENTER;
        8'h4A:   code = "/";
        default: code = 8'd0;
      endcase
    end else begin
      case (scan)
        8'h1C: code = "A";
        8'h32: code = "B";
        8'h21: code = "C";
        8'h23: code = "D";
        8'h24: code = "E";
        8'h2B: code = "F";
        8'h34: code = "G";
        8'h33: code = "H";
        8'h43: code = "I";
        8'h3B: code = "J";
        8'h42: code = "K";
        8'h4B: code = "L";
        8'h3A: code = "M";
        8'h31: code = "N";
        8'h44: code = "O";
        8'h4D: code = "P";
        8'h15: code = "Q";
        8'h2D: code = "R";
        8'h1B: code = "S";
        8'h2C: code = "T";
        8'h3C: code = "U";
        8'h2A: code = "V";
        8'h1D: code = "W";
        8'h22: code = "X";
        8'h35: code = "Y";
        8'h1A: code = "Z";
        8'h16: code = shift ? "!" : "1";
        8'h1E: code = shift ? "@" : "2";
        8'h26: code = shift ? "#" : "3";
        8'h25: code = shift ? "$" : "4";
        8'h2E: code = shift ? "%" : "5";
        8'h36: code = shift ? "^" : "6";
        8'h3D: code = shift ? "&" : "7";
        8'h3E: code = shift ? "*" : "8";
        8'h46: code = shift ? "(" : "9";
        8'h45: code = shift ? ")" : "0";
        8'h0E: code = shift ? 8'd126 : 8'd96;
        8'h4E: code = shift ? "_" : "-";
        8'h55: code = shift ? "+" : "=";
        8'h54: code = shift ? "{" : "[";
        8'h5B: code = shift ? "}" : "]";
        8'h5D: code = shift ? "|" : 8'd92;
        8'h4C: code = shift ? ":" : ";";
        8'h52: code = shift ? 8'd34 : "'";
        8'h41: code = shift ? "<" : ",";
        8'h49: code = shift ? ">" : ".";
        8'h4A: code = shift ? "?" : "/";
        8'h29: code = " ";
        8'h5A: code = HK_ENTER;
        8'h66: code = HK_BKSP;
        8'h76: code = HK_ESC;
        8'h05: code = HK_F1;
        8'h06: code = HK_F2;
        8'h04: code = HK_F3;
        8'h0C: code = HK_F4;
        8'h03: code = HK_F5;
        8'h0B: code = HK_F6;
        8'h83: code = HK_F7;
        8'h0A: code = HK_F8;
        8'h01: code = HK_F9;
        8'h09: code = HK_F10;
        8'h78: code = HK_F11;
        8'h07: code = HK_F12;
        8'h70: code = "0";
        8'h69: code = "1";
        8'h72: code = "2";
        8'h7A: code = "3";
        8'h6B: code = "4";
        8'h73: code = "5";
        8'h74: code = "6";
        8'h6C: code = "7";
        8'h75: code = "8";
        8'h7D: code = "9";
        8'h71: code = ".";
        default: code = 8'd0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_hack_keyboard.sv
// PS/2 receiver feeding the Hack KBD word: synchronises the pins, frames bytes
// and tracks E0/F0/shift prefixes to hold the most recently pressed key.
module ps2_hack_keyboard
  import hack_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input logic clk,
  input logic rst,
  ps2_hack_keyboard_if.slave kbd
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   ps_clk_s;
  logic                   ps_data_s;
  logic                   strobe;

  rx_state_t        state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [7:0]       rx_byte;
  logic             par_err;
  logic             byte_rdy;
  logic             frame_err_r;
  logic [TMO_W-1:0] tmo_cnt;

  logic        e0;
  logic        f0;
  logic        shift_held;
  logic        is_shift_key;
  logic [7:0]  hack_code;
  logic [15:0] key_code_r;
  logic        key_valid_r;
  logic [7:0]  scan_code_r;

  // Sync flops idle high like the PS/2 lines so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd.ps_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], kbd.ps_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps_clk_s  = clk_sync[SYNC_STAGES-1];
  assign ps_data_s = data_sync[SYNC_STAGES-1];
  assign strobe    = clk_prev & ~ps_clk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RX_IDLE;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'd0;
      rx_byte     <= 8'd0;
      par_err     <= 1'b0;
      byte_rdy    <= 1'b0;
      frame_err_r <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      byte_rdy    <= 1'b0;
      frame_err_r <= 1'b0;
      if (strobe) begin
        tmo_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!ps_data_s) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
              par_err <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_reg <= {ps_data_s, shift_reg[7:1]};
            if (bit_cnt == 3'd7) state <= RX_PARITY;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          RX_PARITY: begin
            par_err <= ~(^{shift_reg, ps_data_s});
            state   <= RX_STOP;
          end
          RX_STOP: begin
            if (ps_data_s && !par_err) begin
              byte_rdy <= 1'b1;
              rx_byte  <= shift_reg;
            end else begin
              frame_err_r <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        // A stalled host abandons the partial byte; prefix flags are left alone.
        if (tmo_cnt == TMO_LAST) begin
          frame_err_r <= 1'b1;
          state       <= RX_IDLE;
          tmo_cnt     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  ps2_scan_to_hack u_xlate (
    .e0    (e0),
    .scan  (rx_byte),
    .shift (shift_held),
    .code  (hack_code)
  );

  assign is_shift_key = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      e0          <= 1'b0;
      f0          <= 1'b0;
      shift_held  <= 1'b0;
      key_code_r  <= 16'd0;
      key_valid_r <= 1'b0;
      scan_code_r <= 8'd0;
    end else begin
      key_valid_r <= 1'b0;
      if (byte_rdy) begin
        scan_code_r <= rx_byte;
        if (rx_byte == SC_E0) begin
          e0 <= 1'b1;
        end else if (rx_byte == SC_F0) begin
          f0 <= 1'b1;
        end else begin
          // key_valid only fires on a real change, so typematic repeats stay silent.
          if (is_shift_key) begin
            shift_held <= ~f0;
          end else if (!f0) begin
            if (hack_code != 8'd0 && {8'h00, hack_code} != key_code_r) begin
              key_code_r  <= {8'h00, hack_code};
              key_valid_r <= 1'b1;
            end
          end else if (hack_code != 8'd0 && {8'h00, hack_code} == key_code_r) begin
            key_code_r  <= 16'd0;
            key_valid_r <= 1'b1;
          end
          e0 <= 1'b0;
          f0 <= 1'b0;
        end
      end
    end
  end

  assign kbd.key_code  = key_code_r;
  assign kbd.key_valid = key_valid_r;
  assign kbd.scan_code = scan_code_r;
  assign kbd.frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_hack_keyboard.sv
// Directed and randomized PS/2 frames against a table-driven model of the Hack
// keyboard word, including parity/start/stop/timeout errors and mid-frame reset.
module tb_ps2_hack_keyboard;

  localparam int HALF = 8;
  localparam int GAP  = 8;

  logic clk;
  logic rst;
  ps2_hack_keyboard_if kbd_bus ();

  ps2_hack_keyboard #(
    .TIMEOUT_CYCLES (10000),
    .SYNC_STAGES    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kbd (kbd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int valid_seen;
  int err_seen;

  always @(negedge clk) begin
    if (!rst) begin
      if (kbd_bus.key_valid) valid_seen <= valid_seen + 1;
      if (kbd_bus.frame_err) err_seen <= err_seen + 1;
    end
  end

  int map_plain [256];
  int map_shift [256];
  int map_ext   [256];

  byte unsigned letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned sym_sc [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B,
                                8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h29};
  byte unsigned fkey_sc [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
                                 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  byte unsigned pad_sc [11] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
                                8'h74, 8'h6C, 8'h75, 8'h7D, 8'h71};
  byte unsigned nav_sc [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C,
                                8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
  byte unsigned pool [18] = '{8'h1C, 8'h32, 8'h16, 8'h1E, 8'h4A, 8'h29, 8'h5A,
                              8'h66, 8'h76, 8'h05, 8'h07, 8'h75, 8'h6B, 8'h71,
                              8'h12, 8'h59, 8'h0D, 8'h61};

  bit m_e0, m_f0, m_shift;
  int m_held, m_valid, m_err, m_scan;

  task automatic buildMaps();
    string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string lower   = "1234567890-=[]x;',./ ";
    string upper   = "!@#$%^&*()_+{}|:x<>? ";
    string keypad  = "0123456789.";
    for (int i = 0; i < 256; i++) begin
      map_plain[i] = 0;
      map_shift[i] = 0;
      map_ext[i]   = 0;
    end
    for (int i = 0; i < 26; i++) begin
      map_plain[letter_sc[i]] = int'(letters[i]);
      map_shift[letter_sc[i]] = int'(letters[i]);
    end
    for (int i = 0; i < 21; i++) begin
      map_plain[sym_sc[i]] = int'(lower[i]);
      map_shift[sym_sc[i]] = int'(upper[i]);
    end
    map_plain[8'h5D] = 92;
    map_shift[8'h52] = 34;
    map_plain[8'h0E] = 96;
    map_shift[8'h0E] = 126;
    for (int i = 0; i < 12; i++) begin
      map_plain[fkey_sc[i]] = 141 + i;
      map_shift[fkey_sc[i]] = 141 + i;
    end
    for (int i = 0; i < 11; i++) begin
      map_plain[pad_sc[i]] = int'(keypad[i]);
      map_shift[pad_sc[i]] = int'(keypad[i]);
    end
    map_plain[8'h5A] = 128; map_shift[8'h5A] = 128;
    map_plain[8'h66] = 129; map_shift[8'h66] = 129;
    map_plain[8'h76] = 140; map_shift[8'h76] = 140;
    for (int i = 0; i < 10; i++) map_ext[nav_sc[i]] = 130 + i;
    map_ext[8'h5A] = 128;
    map_ext[8'h4A] = 47;
  endtask

  task automatic modelReset();
    m_e0 = 0; m_f0 = 0; m_shift = 0; m_held = 0; m_scan = 0;
  endtask

  task automatic modelByte(input byte unsigned b);
    int code;
    m_scan = int'(b);
    if (b == 8'hE0) m_e0 = 1;
    else if (b == 8'hF0) m_f0 = 1;
    else begin
      code = m_e0 ? map_ext[b] : (m_shift ? map_shift[b] : map_plain[b]);
      if (b == 8'h12 || b == 8'h59) m_shift = !m_f0;
      else if (!m_f0 && code != 0 && code != m_held) begin
        m_held = code;
        m_valid++;
      end else if (m_f0 && code != 0 && code == m_held) begin
        m_held = 0;
        m_valid++;
      end
      m_e0 = 0;
      m_f0 = 0;
    end
  endtask

  task automatic driveBit(input logic v);
    @(negedge clk);
    kbd_bus.ps_data = v;
    repeat (HALF) @(negedge clk);
    kbd_bus.ps_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    kbd_bus.ps_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit flip_par,
                               input bit stop_bit, input int nbits);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) driveBit(bits[i]);
    kbd_bus.ps_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic sendByte(input byte unsigned b);
    applyStimulus(b, 1'b0, 1'b1, 11);
    modelByte(b);
  endtask

  task automatic checkVal(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".key_code"}, int'(kbd_bus.key_code), m_held);
    checkVal({tag, ".scan_code"}, int'(kbd_bus.scan_code), m_scan);
    checkVal({tag, ".valid_pulses"}, valid_seen, m_valid);
    checkVal({tag, ".err_pulses"}, err_seen, m_err);
  endtask

  initial begin
    int act;
    byte unsigned k;
    checks = 0; failures = 0; valid_seen = 0; err_seen = 0;
    m_valid = 0; m_err = 0;
    buildMaps();
    modelReset();
    kbd_bus.ps_clk = 1'b1;
    kbd_bus.ps_data = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkVal("reset.key_code", int'(kbd_bus.key_code), 0);
    checkVal("reset.key_valid", int'(kbd_bus.key_valid), 0);
    checkVal("reset.scan_code", int'(kbd_bus.scan_code), 0);
    checkVal("reset.frame_err", int'(kbd_bus.frame_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    sendByte(8'h1C);                                 checkOutput("make_A");
    sendByte(8'hF0); sendByte(8'h1C);                checkOutput("break_A");

    sendByte(8'h12); sendByte(8'h16);                checkOutput("shift_bang");
    sendByte(8'hF0); sendByte(8'h12); sendByte(8'h16); checkOutput("plain_1");
    sendByte(8'hF0); sendByte(8'h16);                checkOutput("break_1");

    sendByte(8'hE0); sendByte(8'h75);                checkOutput("make_up");
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75); checkOutput("break_up");
    sendByte(8'h75);                                 checkOutput("keypad_8");
    sendByte(8'hF0); sendByte(8'h75);                checkOutput("break_kp8");

    applyStimulus(8'h1C, 1'b1, 1'b1, 11); m_err++;   checkOutput("parity_err");
    applyStimulus(8'h1C, 1'b0, 1'b0, 11); m_err++;   checkOutput("stop_err");
    driveBit(1'b1); repeat (GAP) @(negedge clk); m_err++; checkOutput("start_err");

    applyStimulus(8'h5A, 1'b0, 1'b1, 5);
    repeat (9880) @(negedge clk);                    checkOutput("before_timeout");
    repeat (120) @(negedge clk); m_err++;            checkOutput("timeout");
    sendByte(8'h5A);                                 checkOutput("enter");
    sendByte(8'hF0); sendByte(8'h5A);                checkOutput("break_enter");

    sendByte(8'h1C);
    sendByte(8'h1C); sendByte(8'h1C); sendByte(8'h1C); checkOutput("typematic");
    sendByte(8'h32);                                 checkOutput("last_wins");
    sendByte(8'hF0); sendByte(8'h1C);                checkOutput("stale_break");
    sendByte(8'hF0); sendByte(8'h32);                checkOutput("break_B");

    sendByte(8'h12); sendByte(8'h1E);
    applyStimulus(8'h3C, 1'b0, 1'b1, 5);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    modelReset();
    repeat (4) @(negedge clk);                       checkOutput("mid_reset");
    sendByte(8'h1E);                                 checkOutput("after_reset");

    for (int i = 0; i < 40; i++) begin
      act = int'($urandom_range(0, 3));
      k = pool[$urandom_range(0, 17)];
      if (act >= 2) sendByte(8'hE0);
      if (act == 1 || act == 3) sendByte(8'hF0);
      sendByte(k);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
